multiplier_fp_uc: RTL and testbench
===================================

// Module: multiplier_fp_uc
// PURPOSE
//  Control unit for the FP multiplier datapath; it sits directly upstream of it.
//  - Accepts a start pulse from the FPU issue logic.
//  - Sequences the datapath's shared exponent adder: exponent sum, denormal adjust, bias subtract, rounding carry.
//  - Launches the Karatsuba mantissa multiply and waits for it.
//  - Strobes the result/flag registers and returns a one-cycle valid to the FPU.
// PARAMETERS
//  MulTimeout  64  max WAIT_MUL cycles before abort; counter width = $clog2(MulTimeout+1)
// PORTS
//  clk              in   1  clock, rising edge
//  rst_n            in   1  asynchronous, active-low reset
//  start            in   1  request a multiply; operands stable at datapath inputs until valid_o
//  flush            in   1  synchronous abort of the current operation
//  denorm_in        in   1  either operand exponent field is zero (from FPU decode)
//  mul_done         in   1  Karatsuba done, level, sampled each cycle
//  start_op         out  1  Karatsuba start pulse
//  sel_a_operand    out  1  adder A select: 0 = exp_a, 1 = exp_result register
//  sel_b_operand    out  2  adder B select: 0 = exp_b, 1 = bias, 2 = carry_rounding, 3 = +1
//  sel_operation    out  2  adder operation: 0 = add, 1 = subtract
//  load_exp_result  out  1  exponent register load
//  load_underflow   out  1  underflow register load
//  load_overflow    out  1  overflow register load
//  load_inexact     out  1  inexact register load
//  load_result      out  1  result register load
//  busy             out  1  high in every state except IDLE
//  valid_o          out  1  one-cycle pulse: datapath result/flags are valid
//  timeout          out  1  sticky; set on WAIT_MUL expiry, cleared by next accepted start
// BEHAVIOUR
//  - Reset (rst_n=0, any time, including mid-operation): state=IDLE, counter=0, all outputs 0.
//  - Outputs are Moore (decoded from state). Values not listed in a state are 0.
//  - IDLE
//    - start=1 & flush=0 -> EXP_ADD; timeout cleared.
//  - EXP_ADD
//    - Drives: sel_a=0, sel_b=0, sel_operation=0; start_op=1, load_exp_result=1, load_underflow=1.
//    - -> DENORM_ADJ if denorm_in, else EXP_BIAS.
//  - DENORM_ADJ
//    - Drives: sel_a=1, sel_b=3, sel_operation=0; load_exp_result=1.
//    - -> EXP_BIAS.
//  - EXP_BIAS
//    - Drives: sel_a=1, sel_b=1, sel_operation=1; load_exp_result=1, load_overflow=1.
//    - -> WAIT_MUL; counter cleared.
//  - WAIT_MUL
//    - Drives: sel_a=1, no loads.
//    - mul_done=1 -> ROUND.
//    - Otherwise counter+1; when counter==MulTimeout -> IDLE with timeout=1 and no valid_o.
//  - ROUND
//    - Drives: sel_a=1, sel_b=2, sel_operation=0; load_overflow=1 (captures rounding carry-out), load_inexact=1.
//    - load_exp_result stays 0, so the carry is never added twice.
//    - -> WRITE.
//  - WRITE
//    - Drives the same selects as ROUND; load_result=1.
//    - -> DONE.
//  - DONE
//    - Drives: valid_o=1.
//    - -> IDLE. A start in DONE is ignored; back-to-back issue starts from IDLE on the next cycle.
//  - Latency, start sampled at edge 0 with mul_done already high:
//    - normal operands: valid_o in cycle 6;
//    - denorm_in=1: valid_o in cycle 7.
//  - Boundary rules:
//    - start while busy: ignored; no queueing.
//    - flush in any non-IDLE state -> IDLE next edge; no valid_o, no further loads.
//    - flush and mul_done in the same cycle: flush wins.
//    - flush and start in IDLE: stay IDLE.
//    - mul_done high before WAIT_MUL: still accepted on the first WAIT_MUL cycle.
//    - counter saturates and never wraps.
// STRUCTURE
//  - Package fp_mul_pkg holds:
//    - state enum (8 states, binary encoded);
//    - SEL_A_EXP/SEL_A_REG;
//    - SEL_B_EXP/SEL_B_BIAS/SEL_B_CARRY/SEL_B_ONE;
//    - OP_ADD/OP_SUB.
//  - One sub-module: wait_counter, a saturating counter with clear/enable/expired outputs.
//  - State register and output decode stay in this module.
// TESTING
//  1. Reset mid-WAIT_MUL: rst_n low for 1 cycle -> busy=0 and all loads 0 immediately (asynchronous); next start runs normally.
//  2. Normal multiply, denorm_in=0, mul_done high:
//     - start at cycle 0 -> start_op=1 in cycle 1, load_overflow in cycles 2 and 4, load_result in cycle 5, valid_o in cycle 6 only.
//  3. denorm_in=1 -> DENORM_ADJ inserted with sel_b=3 and load_exp_result; valid_o in cycle 7.
//  4. mul_done held low, MulTimeout=4 -> 4 WAIT_MUL cycles, then IDLE with timeout=1 and valid_o never asserted.
//  5. flush in ROUND -> load_result never asserted; busy=0 next cycle.
//  6. start pulsed while busy -> exactly one valid_o; then a start in IDLE is accepted.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and select encodings for the FP multiplier control unit.
package fp_mul_pkg;

  // Control sequence states, binary encoded.
  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StExpAdd    = 3'd1,
    StDenormAdj = 3'd2,
    StExpBias   = 3'd3,
    StWaitMul   = 3'd4,
    StRound     = 3'd5,
    StWrite     = 3'd6,
    StDone      = 3'd7
  } state_e;

  // Exponent adder operand A select.
  localparam logic SEL_A_EXP = 1'b0;
  localparam logic SEL_A_REG = 1'b1;

  // Exponent adder operand B select.
  localparam logic [1:0] SEL_B_EXP   = 2'd0;
  localparam logic [1:0] SEL_B_BIAS  = 2'd1;
  localparam logic [1:0] SEL_B_CARRY = 2'd2;
  localparam logic [1:0] SEL_B_ONE   = 2'd3;

  // Exponent adder operation.
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;

endpackage

// File: rtl/wait_counter.sv
// Saturating cycle counter bounding the wait for the mantissa multiplier.
module wait_counter #(
  parameter int unsigned MaxCount = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(MaxCount + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MaxCount);
  localparam logic [CntW-1:0] CntLast = CntW'(MaxCount - 1);

  logic [CntW-1:0] count_q, count_d;

  // Clear wins over enable; hold at CntMax instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != CntMax)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expires on the cycle whose increment would reach MaxCount, giving MaxCount wait cycles.
  always_comb begin
    expired = en && (count_q >= CntLast);
  end

endmodule

// File: rtl/multiplier_fp_uc.sv
// Control unit for the FP multiplier datapath: sequences the shared exponent adder,
// launches the Karatsuba mantissa multiply and strobes the result/flag registers.
module multiplier_fp_uc
  import fp_mul_pkg::*;
#(
  parameter int unsigned MulTimeout = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       flush,
  input  logic       denorm_in,
  input  logic       mul_done,
  output logic       start_op,
  output logic       sel_a_operand,
  output logic [1:0] sel_b_operand,
  output logic [1:0] sel_operation,
  output logic       load_exp_result,
  output logic       load_underflow,
  output logic       load_overflow,
  output logic       load_inexact,
  output logic       load_result,
  output logic       busy,
  output logic       valid_o,
  output logic       timeout
);

  state_e state_q, state_d;
  logic   timeout_q, timeout_d;
  logic   cnt_clr, cnt_en, cnt_expired;

  // Counter restarts on the way into WAIT_MUL and only advances while still waiting.
  always_comb begin
    cnt_clr = (state_q == StExpBias);
    cnt_en  = (state_q == StWaitMul) && !mul_done;
  end

  wait_counter #(
    .MaxCount (MulTimeout)
  ) u_wait_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expired (cnt_expired)
  );

  // Next-state and sticky timeout; flush overrides every other transition.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          state_d   = StExpAdd;
          timeout_d = 1'b0;
        end
      end
      StExpAdd:    state_d = denorm_in ? StDenormAdj : StExpBias;
      StDenormAdj: state_d = StExpBias;
      StExpBias:   state_d = StWaitMul;
      StWaitMul: begin
        if (mul_done) begin
          state_d = StRound;
        end else if (cnt_expired) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end
      end
      StRound:     state_d = StWrite;
      StWrite:     state_d = StDone;
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    if (flush && (state_q != StIdle)) begin
      state_d   = StIdle;
      timeout_d = timeout_q;
    end
  end

  // State and timeout flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  // Moore output decode; anything not driven in a state stays 0.
  always_comb begin
    start_op        = 1'b0;
    sel_a_operand   = SEL_A_EXP;
    sel_b_operand   = SEL_B_EXP;
    sel_operation   = OP_ADD;
    load_exp_result = 1'b0;
    load_underflow  = 1'b0;
    load_overflow   = 1'b0;
    load_inexact    = 1'b0;
    load_result     = 1'b0;
    valid_o         = 1'b0;
    busy            = (state_q != StIdle);
    timeout         = timeout_q;
    unique case (state_q)
      StIdle: ;
      StExpAdd: begin
        start_op        = 1'b1;
        load_exp_result = 1'b1;
        load_underflow  = 1'b1;
      end
      StDenormAdj: begin
        sel_a_operand   = SEL_A_REG;
        sel_b_operand   = SEL_B_ONE;
        load_exp_result = 1'b1;
      end
      StExpBias: begin
        sel_a_operand   = SEL_A_REG;
        sel_b_operand   = SEL_B_BIAS;
        sel_operation   = OP_SUB;
        load_exp_result = 1'b1;
        load_overflow   = 1'b1;
      end
      StWaitMul: begin
        sel_a_operand = SEL_A_REG;
      end
      StRound: begin
        // Exponent register is not loaded here so the rounding carry is added only once.
        sel_a_operand = SEL_A_REG;
        sel_b_operand = SEL_B_CARRY;
        load_overflow = 1'b1;
        load_inexact  = 1'b1;
      end
      StWrite: begin
        sel_a_operand = SEL_A_REG;
        sel_b_operand = SEL_B_CARRY;
        load_result   = 1'b1;
      end
      StDone: begin
        valid_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multiplier_fp_uc.sv
// Self-checking bench for multiplier_fp_uc using a schedule-list reference model.
module tb_multiplier_fp_uc;

  localparam int unsigned Tmo = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       flush = 1'b0;
  logic       denorm_in = 1'b0;
  logic       mul_done = 1'b0;
  logic       start_op, sel_a_operand, load_exp_result, load_underflow, load_overflow;
  logic       load_inexact, load_result, busy, valid_o, timeout;
  logic [1:0] sel_b_operand, sel_operation;
  logic [12:0] obs;

  int  n_cmp = 0;
  int  n_err = 0;
  logic exp_to = 1'b0;

  multiplier_fp_uc #(
    .MulTimeout (Tmo)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .flush           (flush),
    .denorm_in       (denorm_in),
    .mul_done        (mul_done),
    .start_op        (start_op),
    .sel_a_operand   (sel_a_operand),
    .sel_b_operand   (sel_b_operand),
    .sel_operation   (sel_operation),
    .load_exp_result (load_exp_result),
    .load_underflow  (load_underflow),
    .load_overflow   (load_overflow),
    .load_inexact    (load_inexact),
    .load_result     (load_result),
    .busy            (busy),
    .valid_o         (valid_o),
    .timeout         (timeout)
  );

  always #5 clk = ~clk;

  assign obs = {start_op, sel_a_operand, sel_b_operand, sel_operation, load_exp_result,
                load_underflow, load_overflow, load_inexact, load_result, busy, valid_o};

  // Expected output word for one cycle of activity.
  function automatic logic [12:0] mk(input logic so, input logic sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic le, input logic lu,
                                     input logic lo, input logic li, input logic lr,
                                     input logic bz, input logic vl);
    return {so, sa, sb, op, le, lu, lo, li, lr, bz, vl};
  endfunction

  logic [12:0] w_idle, w_add, w_dn, w_bias, w_wait, w_round, w_write, w_done;
  initial begin
    w_idle  = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    w_add   = mk(1, 0, 2'd0, 2'd0, 1, 1, 0, 0, 0, 1, 0);
    w_dn    = mk(0, 1, 2'd3, 2'd0, 1, 0, 0, 0, 0, 1, 0);
    w_bias  = mk(0, 1, 2'd1, 2'd1, 1, 0, 1, 0, 0, 1, 0);
    w_wait  = mk(0, 1, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0);
    w_round = mk(0, 1, 2'd2, 2'd0, 0, 0, 1, 1, 0, 1, 0);
    w_write = mk(0, 1, 2'd2, 2'd0, 0, 0, 0, 0, 1, 1, 0);
    w_done  = mk(0, 0, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation: start in the current (idle) cycle, mul_done high from cycle m on,
  // flush in cycle f (<=0 means none), optional start pulses while busy.
  task automatic run_op(input logic dn, input int m, input int f, input bit noise,
                        output int vcyc, output int nvalid, output int nres);
    logic [12:0] q[$];
    int w, stop, n;
    bit to;
    q = {};
    to = 0;
    q.push_back(w_add);
    if (dn) q.push_back(w_dn);
    q.push_back(w_bias);
    w = q.size() + 1;
    stop = (m > w) ? m : w;
    n = stop - w + 1;
    if (n > int'(Tmo)) begin
      for (int i = 0; i < int'(Tmo); i++) q.push_back(w_wait);
      to = 1;
    end else begin
      for (int i = 0; i < n; i++) q.push_back(w_wait);
      q.push_back(w_round);
      q.push_back(w_write);
      q.push_back(w_done);
    end
    if (f >= 1 && f <= q.size()) begin
      while (q.size() > f) void'(q.pop_back());
      to = 0;
    end
    vcyc = -1;
    nvalid = 0;
    nres = 0;
    start = 1'b1;
    flush = 1'b0;
    denorm_in = dn;
    mul_done = (m <= 0);
    n_cmp++;
    if (obs !== w_idle || timeout !== exp_to) begin
      n_err++;
      $display("FAIL op_idle got=%h/%b want=%h/%b", obs, timeout, w_idle, exp_to);
    end
    step();
    for (int c = 1; c <= q.size(); c++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      flush = (c == f);
      mul_done = (c >= m);
      n_cmp++;
      if (obs !== q[c-1] || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL op_cycle c=%0d got=%h/%b want=%h/0", c, obs, timeout, q[c-1]);
      end
      if (valid_o === 1'b1) begin
        if (vcyc < 0) vcyc = c;
        nvalid++;
      end
      if (load_result === 1'b1) nres++;
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    mul_done = 1'b0;
    exp_to = to;
    n_cmp++;
    if (obs !== w_idle || timeout !== exp_to) begin
      n_err++;
      $display("FAIL op_end got=%h/%b want=%h/%b", obs, timeout, w_idle, exp_to);
    end
  endtask

  task automatic test_reset();
    int vc, nv, nr;
    step();
    n_cmp++;
    if (obs !== w_idle || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state got=%h/%b want=%h/0", obs, timeout, w_idle);
    end
    rst_n = 1'b1;
    step();
    start = 1'b1;
    mul_done = 1'b0;
    denorm_in = 1'b0;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if (obs !== w_wait) begin
      n_err++;
      $display("FAIL reset_pre_wait got=%h want=%h", obs, w_wait);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || obs !== w_idle) begin
      n_err++;
      $display("FAIL reset_async got=%h want=%h", obs, w_idle);
    end
    step();
    rst_n = 1'b1;
    step();
    exp_to = 1'b0;
    run_op(1'b0, 0, 0, 1'b0, vc, nv, nr);
    n_cmp++;
    if (vc !== 6 || nv !== 1) begin
      n_err++;
      $display("FAIL reset_rerun got=%0d/%0d want=6/1", vc, nv);
    end
  endtask

  task automatic test_normal();
    int vc, nv, nr;
    run_op(1'b0, 0, 0, 1'b0, vc, nv, nr);
    n_cmp++;
    if (vc !== 6 || nv !== 1 || nr !== 1) begin
      n_err++;
      $display("FAIL normal_latency got=%0d/%0d/%0d want=6/1/1", vc, nv, nr);
    end
  endtask

  task automatic test_denorm();
    int vc, nv, nr;
    run_op(1'b1, 0, 0, 1'b0, vc, nv, nr);
    n_cmp++;
    if (vc !== 7 || nv !== 1) begin
      n_err++;
      $display("FAIL denorm_latency got=%0d/%0d want=7/1", vc, nv);
    end
  endtask

  task automatic test_timeout();
    int vc, nv, nr;
    run_op(1'b0, 1000, 0, 1'b0, vc, nv, nr);
    n_cmp++;
    if (nv !== 0 || timeout !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_abort got=%0d/%b/%b want=0/1/0", nv, timeout, busy);
    end
    // Next accepted start clears the sticky flag (checked inside run_op).
    run_op(1'b0, 0, 0, 1'b0, vc, nv, nr);
    n_cmp++;
    if (timeout !== 1'b0 || nv !== 1) begin
      n_err++;
      $display("FAIL timeout_clear got=%b/%0d want=0/1", timeout, nv);
    end
  endtask

  task automatic test_flush_round();
    int vc, nv, nr;
    run_op(1'b0, 0, 4, 1'b0, vc, nv, nr);
    n_cmp++;
    if (nr !== 0 || nv !== 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_round got=%0d/%0d/%b want=0/0/0", nr, nv, busy);
    end
  endtask

  task automatic test_flush_start_idle();
    start = 1'b1;
    flush = 1'b1;
    step();
    start = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || obs !== w_idle) begin
      n_err++;
      $display("FAIL flush_start_idle got=%h want=%h", obs, w_idle);
    end
  endtask

  task automatic test_back_to_back();
    int vc, nv, nr;
    for (int k = 0; k < 3; k++) begin
      run_op(1'(k == 1), 0, 0, 1'b1, vc, nv, nr);
      n_cmp++;
      if (nv !== 1 || vc !== ((k == 1) ? 7 : 6)) begin
        n_err++;
        $display("FAIL back_to_back k=%0d got=%0d/%0d want=1/%0d", k, nv, vc,
                 (k == 1) ? 7 : 6);
      end
    end
  endtask

  task automatic test_random();
    int vc, nv, nr, m, f;
    logic dn;
    bit noise;
    for (int k = 0; k < 40; k++) begin
      dn = 1'($urandom_range(0, 1));
      m = int'($urandom_range(0, 10));
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 12)) : 0;
      noise = 1'($urandom_range(0, 1));
      run_op(dn, m, f, noise, vc, nv, nr);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_denorm();
    test_timeout();
    test_flush_round();
    test_flush_start_idle();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop in case stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
